// File: rtl/mte_sequencer.sv
// mte_sequencer: runs one request at a time through a fixed-latency
// MAC/encrypt/decrypt engine and returns the auth-gated result.
module mte_sequencer #(
    parameter int N   = 256,
    parameter int LAT = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_sel,
    input  logic [N-1:0] req_data,
    input  logic [N-1:0] req_key,
    output logic [N-1:0] eng_key,
    output logic [N-1:0] eng_in,
    output logic         eng_sel,
    output logic         eng_start,
    input  logic [N-1:0] eng_out,
    input  logic         eng_valid_key,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [N-1:0] rsp_data,
    output logic         rsp_auth_fail,
    output logic         busy,
    output logic [7:0]   fail_count
);
    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_e;

    localparam logic [7:0] CNT_INIT = 8'(LAT - 1);

    state_e         state_q;
    logic [7:0]     cnt_q;
    logic [N-1:0]   key_q;
    logic [N-1:0]   in_q;
    logic           sel_q;
    logic           start_q;
    logic           rsp_valid_q;
    logic [N-1:0]   rsp_data_q;
    logic           fail_q;
    logic           busy_q;
    logic [7:0]     fail_cnt_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 8'd0;
            key_q       <= '0;
            in_q        <= '0;
            sel_q       <= 1'b0;
            start_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            fail_q      <= 1'b0;
            busy_q      <= 1'b0;
            fail_cnt_q  <= 8'd0;
        end else begin
            start_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        key_q   <= req_key;
                        in_q    <= req_data;
                        sel_q   <= req_sel;
                        start_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    cnt_q   <= CNT_INIT;
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (cnt_q != 8'd0) begin
                        cnt_q <= cnt_q - 8'd1;
                    end else begin
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                        // decrypt with a failed MAC compare never leaks data
                        if (sel_q || eng_valid_key) begin
                            rsp_data_q <= eng_out;
                            fail_q     <= 1'b0;
                        end else begin
                            rsp_data_q <= '0;
                            fail_q     <= 1'b1;
                            if (fail_cnt_q != 8'hFF)
                                fail_cnt_q <= fail_cnt_q + 8'd1;
                        end
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready     = (state_q == IDLE) && !reset;
    assign eng_key       = key_q;
    assign eng_in        = in_q;
    assign eng_sel       = sel_q;
    assign eng_start     = start_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_data      = rsp_data_q;
    assign rsp_auth_fail = fail_q;
    assign busy          = busy_q;
    assign fail_count    = fail_cnt_q;

endmodule

// File: tb/tb_mte_sequencer.sv
// tb_mte_sequencer: randomized self-checking bench with a latency-exact
// engine model, one DUT at LAT=4 and one at LAT=1.
module tb_mte_sequencer;
    localparam int N    = 256;
    localparam int LAT  = 4;
    localparam int LAT1 = 1;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic         req_valid, req_ready, req_sel;
    logic [N-1:0] req_data, req_key, eng_key, eng_in, eng_out, rsp_data;
    logic         eng_sel, eng_start, eng_valid_key;
    logic         rsp_valid, rsp_ready, rsp_auth_fail, busy;
    logic [7:0]   fail_count;

    logic         b_req_valid, b_req_ready, b_req_sel;
    logic [N-1:0] b_req_data, b_req_key, b_eng_key, b_eng_in;
    logic [N-1:0] b_eng_out, b_rsp_data;
    logic         b_eng_sel, b_eng_start, b_eng_valid_key;
    logic         b_rsp_valid, b_rsp_ready, b_rsp_auth_fail, b_busy;
    logic [7:0]   b_fail_count;

    mte_sequencer #(.N(N), .LAT(LAT)) u_dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_sel(req_sel), .req_data(req_data), .req_key(req_key),
        .eng_key(eng_key), .eng_in(eng_in), .eng_sel(eng_sel),
        .eng_start(eng_start), .eng_out(eng_out),
        .eng_valid_key(eng_valid_key),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_auth_fail(rsp_auth_fail),
        .busy(busy), .fail_count(fail_count)
    );

    mte_sequencer #(.N(N), .LAT(LAT1)) u_dut1 (
        .clock(clock), .reset(reset),
        .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_sel(b_req_sel), .req_data(b_req_data), .req_key(b_req_key),
        .eng_key(b_eng_key), .eng_in(b_eng_in), .eng_sel(b_eng_sel),
        .eng_start(b_eng_start), .eng_out(b_eng_out),
        .eng_valid_key(b_eng_valid_key),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
        .rsp_data(b_rsp_data), .rsp_auth_fail(b_rsp_auth_fail),
        .busy(b_busy), .fail_count(b_fail_count)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [N-1:0] got,
                       input logic [N-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Engine models: result is valid only in the cycle before edge start+LAT.
    logic mac_ok = 1'b1;
    logic b_mac_ok = 1'b1;
    int   ecnt = 0;
    int   b_ecnt = 0;

    initial begin
        eng_out = '0; eng_valid_key = 1'b0;
        b_eng_out = '0; b_eng_valid_key = 1'b0;
    end

    always @(posedge clock or posedge reset) begin
        if (reset) ecnt = 0;
        else if (eng_start) ecnt = LAT;
        else if (ecnt > 0) ecnt--;
        #1;
        if (ecnt == 1) begin
            eng_out = eng_in ^ eng_key;
            eng_valid_key = mac_ok;
        end else begin
            eng_out = {8{$urandom}};
            eng_valid_key = 1'($urandom);
        end
    end

    always @(posedge clock or posedge reset) begin
        if (reset) b_ecnt = 0;
        else if (b_eng_start) b_ecnt = LAT1;
        else if (b_ecnt > 0) b_ecnt--;
        #1;
        if (b_ecnt == 1) begin
            b_eng_out = b_eng_in ^ b_eng_key;
            b_eng_valid_key = b_mac_ok;
        end else begin
            b_eng_out = {8{$urandom}};
            b_eng_valid_key = 1'($urandom);
        end
    end

    logic prev_start = 1'b0;
    logic b_prev_start = 1'b0;
    always @(negedge clock) begin
        if (!reset) begin
            if (prev_start) chk("start_width", N'(eng_start), N'(0));
            if (b_prev_start) chk("b_start_width", N'(b_eng_start), N'(0));
        end
        prev_start = eng_start;
        b_prev_start = b_eng_start;
    end

    int exp_fails = 0;
    int b_exp_fails = 0;

    logic         pend_sel;
    logic [N-1:0] pend_data, pend_key;

    task automatic issue(input logic sel, input logic [N-1:0] d,
                         input logic [N-1:0] k, input logic ok);
        int n;
        @(negedge clock);
        req_valid = 1'b1; req_sel = sel;
        req_data = d; req_key = k; mac_ok = ok;
        n = 0;
        while (!req_ready && n < 40) begin
            @(negedge clock);
            n++;
        end
        chk("accept_wait", N'(n), N'(0));
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        req_data = {8{$urandom}};
        req_key = {8{$urandom}};
        req_sel = 1'($urandom);
    endtask

    task automatic collect(input logic sel, input logic [N-1:0] d,
                           input logic [N-1:0] k, input logic ok,
                           input int stall, input logic pend);
        int kk;
        logic [N-1:0] exp_d, hold;
        logic exp_f;
        exp_f = !sel && !ok;
        exp_d = exp_f ? '0 : (d ^ k);
        if (exp_f && exp_fails < 255) exp_fails++;
        chk("start_hi", N'(eng_start), N'(1));
        chk("eng_in", eng_in, d);
        chk("eng_key", eng_key, k);
        chk("eng_sel", N'(eng_sel), N'(sel));
        chk("busy_on", N'(busy), N'(1));
        kk = 0;
        do begin
            @(posedge clock);
            #1;
            kk++;
            if (kk == 1) chk("start_lo", N'(eng_start), N'(0));
        end while (!rsp_valid && kk < LAT + 20);
        chk("latency", N'(kk), N'(LAT + 1));
        chk("rsp_data", rsp_data, exp_d);
        chk("auth_fail", N'(rsp_auth_fail), N'(exp_f));
        chk("fail_count", N'(fail_count), N'(exp_fails));
        hold = rsp_data;
        if (pend) begin
            req_valid = 1'b1; req_sel = pend_sel;
            req_data = pend_data; req_key = pend_key;
        end
        repeat (stall) begin
            @(posedge clock);
            #1;
            chk("stall_vld", N'(rsp_valid), N'(1));
            chk("stall_data", rsp_data, hold);
            chk("stall_rdy", N'(req_ready), N'(0));
            chk("stall_in", eng_in, d);
        end
        rsp_ready = 1'b1;
        @(posedge clock);
        #1;
        rsp_ready = 1'b0;
        chk("rsp_drop", N'(rsp_valid), N'(0));
        chk("idle_rdy", N'(req_ready), N'(1));
        chk("idle_in", eng_in, d);
        chk("busy_off", N'(busy), N'(0));
    endtask

    task automatic txn(input logic sel, input logic [N-1:0] d,
                       input logic [N-1:0] k, input logic ok,
                       input int stall);
        issue(sel, d, k, ok);
        collect(sel, d, k, ok, stall, 1'b0);
    endtask

    task automatic b_txn(input logic sel, input logic [N-1:0] d,
                         input logic [N-1:0] k, input logic ok);
        int n;
        logic [N-1:0] exp_d;
        logic exp_f;
        exp_f = !sel && !ok;
        exp_d = exp_f ? '0 : (d ^ k);
        if (exp_f && b_exp_fails < 255) b_exp_fails++;
        @(negedge clock);
        b_req_valid = 1'b1; b_req_sel = sel;
        b_req_data = d; b_req_key = k; b_mac_ok = ok;
        n = 0;
        while (!b_req_ready && n < 40) begin
            @(negedge clock);
            n++;
        end
        chk("b_accept_wait", N'(n), N'(0));
        @(posedge clock);
        #1;
        b_req_valid = 1'b0;
        b_req_data = {8{$urandom}};
        n = 0;
        do begin
            @(posedge clock);
            #1;
            n++;
        end while (!b_rsp_valid && n < 20);
        chk("b_latency", N'(n), N'(LAT1 + 1));
        chk("b_rsp_data", b_rsp_data, exp_d);
        chk("b_auth_fail", N'(b_rsp_auth_fail), N'(exp_f));
        chk("b_fail_count", N'(b_fail_count), N'(b_exp_fails));
        @(posedge clock);
        #1;
        chk("b_rsp_drop", N'(b_rsp_valid), N'(0));
    endtask

    initial begin
        logic [N-1:0] d0, k0, a5;
        reset = 1'b1;
        req_valid = 1'b0; req_sel = 1'b0; req_data = '0; req_key = '0;
        rsp_ready = 1'b0;
        b_req_valid = 1'b0; b_req_sel = 1'b0;
        b_req_data = '0; b_req_key = '0; b_rsp_ready = 1'b1;
        repeat (3) @(negedge clock);
        chk("rst_ready", N'(req_ready), N'(0));
        chk("rst_busy", N'(busy), N'(0));
        chk("rst_rsp_vld", N'(rsp_valid), N'(0));
        chk("rst_eng_in", eng_in, '0);
        chk("rst_fail_cnt", N'(fail_count), N'(0));
        reset = 1'b0;
        @(negedge clock);
        chk("post_rst_rdy", N'(req_ready), N'(1));

        // reset two cycles into WAIT on a failing decrypt
        issue(1'b0, {8{$urandom}}, {8{$urandom}}, 1'b0);
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("mid_busy", N'(busy), N'(0));
        chk("mid_ready", N'(req_ready), N'(0));
        chk("mid_start", N'(eng_start), N'(0));
        chk("mid_eng_in", eng_in, '0);
        chk("mid_eng_key", eng_key, '0);
        chk("mid_eng_sel", N'(eng_sel), N'(0));
        chk("mid_rsp_data", rsp_data, '0);
        @(negedge clock);
        reset = 1'b0;
        exp_fails = 0;
        b_exp_fails = 0;
        repeat (LAT + 4) begin
            @(negedge clock);
            chk("mid_no_rsp", N'(rsp_valid), N'(0));
            chk("mid_fail_cnt", N'(fail_count), N'(0));
        end

        a5 = '0;
        for (int i = 0; i < N / 8; i++) a5[i*8 +: 8] = 8'hA5;
        txn(1'b1, a5, {8{$urandom}}, 1'b0, 0);
        d0 = N'(16'h1234);
        txn(1'b0, d0, '0, 1'b1, 0);
        txn(1'b0, d0, '0, 1'b0, 0);

        // backpressure with a second request already waiting
        d0 = {8{$urandom}};
        k0 = {8{$urandom}};
        pend_sel = 1'b1;
        pend_data = {8{$urandom}};
        pend_key = {8{$urandom}};
        issue(1'b1, d0, k0, 1'b1);
        collect(1'b1, d0, k0, 1'b1, 10, 1'b1);
        d0 = pend_data;
        k0 = pend_key;
        issue(pend_sel, d0, k0, 1'b1);
        collect(pend_sel, d0, k0, 1'b1, 0, 1'b0);

        for (int i = 0; i < 24; i++)
            txn(1'($urandom), {8{$urandom}}, {8{$urandom}},
                1'($urandom), int'($urandom_range(0, 3)));

        for (int i = 0; i < 300; i++)
            txn(1'b0, {8{$urandom}}, {8{$urandom}}, 1'b0, 0);
        chk("fail_sat", N'(fail_count), N'(255));

        b_txn(1'b1, a5, {8{$urandom}}, 1'b0);
        b_txn(1'b0, N'(16'h1234), '0, 1'b1);
        b_txn(1'b0, N'(16'h1234), '0, 1'b0);
        for (int i = 0; i < 12; i++)
            b_txn(1'($urandom), {8{$urandom}}, {8{$urandom}},
                  1'($urandom));

        repeat (2) @(negedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
